// File: rtl/fc_result_reader.sv
// Result reader for the fully connected layer: snapshots the scores on each fc_done rising edge,
// finds the argmax one class per cycle, then raises the result/IRQ and streams every score out.
module fc_result_reader #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fc_done,
  input  logic [NUM_CLASSES*SCORE_W-1:0] fc_scores,
  output logic                           result_valid,
  output logic [IDX_W-1:0]               result_class,
  output logic [SCORE_W-1:0]             result_score,
  output logic                           result_irq,
  input  logic                           result_ack,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [SCORE_W-1:0]             m_data,
  output logic [IDX_W-1:0]               m_index,
  output logic                           m_last,
  output logic                           busy,
  output logic                           overrun
);
  typedef enum logic [1:0] {IDLE, SCAN, STREAM, HOLD} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_t state, state_nx;
  logic fc_done_q, new_res, capture, take, at_last, accept;
  logic [IDX_W-1:0] idx, max_idx;
  logic signed [SCORE_W-1:0] max_val, cur;
  logic signed [SCORE_W-1:0] fc_word   [NUM_CLASSES];
  logic signed [SCORE_W-1:0] score_buf [NUM_CLASSES];

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_unpack
    assign fc_word[i] = fc_scores[i*SCORE_W +: SCORE_W];
  end

  assign new_res = fc_done & ~fc_done_q;
  // An ack taken in HOLD frees the buffer in the same cycle, so a coincident edge is captured.
  assign capture = new_res & ((state == IDLE) | ((state == HOLD) & result_ack));
  assign cur     = score_buf[idx];
  assign at_last = (idx == LAST);
  // Strict greater-than keeps the lowest index on ties.
  assign take    = (idx == '0) | (cur > max_val);
  assign accept  = m_valid & m_ready;

  assign busy    = (state != IDLE);
  assign m_valid = (state == STREAM);
  assign m_data  = m_valid ? cur : '0;
  assign m_index = m_valid ? idx : '0;
  assign m_last  = m_valid & at_last;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (new_res) state_nx = SCAN;
      SCAN:    if (at_last) state_nx = STREAM;
      STREAM:  if (accept && at_last) state_nx = HOLD;
      HOLD:    if (result_ack) state_nx = new_res ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fc_done_q    <= 1'b1;
      idx          <= '0;
      max_idx      <= '0;
      max_val      <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      result_irq   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state      <= state_nx;
      fc_done_q  <= fc_done;
      result_irq <= 1'b0;
      case (state)
        SCAN: begin
          if (take) begin
            max_val <= cur;
            max_idx <= idx;
          end
          if (at_last) begin
            idx          <= '0;
            result_valid <= 1'b1;
            result_irq   <= 1'b1;
            result_class <= take ? idx : max_idx;
            result_score <= take ? cur : max_val;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        STREAM: if (accept && !at_last) idx <= idx + 1'b1;
        HOLD:   if (result_ack) result_valid <= 1'b0;
        default: ;
      endcase
      if (capture) idx <= '0;
      if ((state == HOLD) && result_ack) overrun <= 1'b0;
      else if (new_res && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // Buffer content is irrelevant until a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) score_buf[i] <= fc_word[i];
    end
  end
endmodule

// File: tb/tb_fc_result_reader.sv
// Directed plus randomized bench for fc_result_reader; expected argmax and stream words
// come from a plain first-maximum search over the scores the bench drove.
module tb_fc_result_reader;
  localparam int N = 10;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset, fc_done, result_ack, m_ready;
  logic [N*W-1:0] fc_scores;
  logic           result_valid, result_irq, m_valid, m_last, busy, overrun;
  logic [3:0]     result_class, m_index;
  logic [W-1:0]   result_score, m_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] cur_sc [N];
  int exp_cls;

  fc_result_reader #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .fc_done(fc_done), .fc_scores(fc_scores),
    .result_valid(result_valid), .result_class(result_class), .result_score(result_score),
    .result_irq(result_irq), .result_ack(result_ack), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) fc_scores[i*W +: W] = cur_sc[i];
  endtask

  task automatic rand_scores();
    for (int i = 0; i < N; i++)
      cur_sc[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 6)) - 32'd3 : 32'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_cls"}, result_class, 0);
    chk({tag, "_score"}, result_score, 0);
    chk({tag, "_irq"}, result_irq, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_mindex"}, m_index, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Caller has set fc_done=1 (rising) and fc_scores; the next edge is the capture edge.
  task automatic scan_phase();
    step();
    fc_done = 1'b0;
    result_ack = 1'b0;
    chk("capture_busy", busy, 1);
    chk("capture_rv", result_valid, 0);
    chk("capture_overrun", overrun, 0);
    exp_cls = 0;
    for (int i = 1; i < N; i++)
      if ($signed(cur_sc[i]) > $signed(cur_sc[exp_cls])) exp_cls = i;
    for (int c = 1; c <= N; c++) begin
      step();
      if (c < N) begin
        chk("scan_irq", result_irq, 0);
        chk("scan_rv", result_valid, 0);
      end else begin
        chk("res_rv", result_valid, 1);
        chk("res_irq", result_irq, 1);
        chk("res_class", result_class, exp_cls);
        chk("res_score", result_score, cur_sc[exp_cls]);
        chk("res_mvalid", m_valid, 1);
      end
    end
  endtask

  task automatic stream_phase(input int mode, input bit inject);
    int got = 0;
    int cyc = 0;
    logic rdy;
    while (got < N && cyc < 200) begin
      chk("st_mvalid", m_valid, 1);
      chk("st_index", m_index, got);
      chk("st_data", m_data, cur_sc[got]);
      chk("st_last", m_last, (got == N - 1));
      chk("st_rv", result_valid, 1);
      if (cyc > 0) chk("st_irq", result_irq, 0);
      rdy = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      m_ready = rdy;
      if (inject && cyc == 2) begin
        fc_done = 1'b1;
        fc_scores = ~fc_scores;
        result_ack = 1'b1;
      end
      if (inject && cyc == 3) begin
        fc_done = 1'b0;
        result_ack = 1'b0;
        chk("ovr_set", overrun, 1);
      end
      step();
      if (rdy) got++;
      cyc++;
    end
    chk("stream_done", got, N);
    m_ready = 1'b0;
    chk("hold_mvalid", m_valid, 0);
    chk("hold_busy", busy, 1);
    chk("hold_rv", result_valid, 1);
    chk("hold_irq", result_irq, 0);
    chk("hold_overrun", overrun, inject);
  endtask

  task automatic hold_ack();
    repeat (2) begin
      step();
      chk("hold2_irq", result_irq, 0);
      chk("hold2_rv", result_valid, 1);
      chk("hold2_class", result_class, exp_cls);
    end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("ack_rv", result_valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_overrun", overrun, 0);
    chk("ack_mvalid", m_valid, 0);
  endtask

  initial begin
    reset = 1'b1; fc_done = 1'b1; result_ack = 1'b0; m_ready = 1'b0; fc_scores = '0;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) step();
    chk_zero("held_done");
    fc_done = 1'b0;
    step();

    // Basic with a tie at the maximum; lowest index wins.
    cur_sc = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd0, 32'd99, -32'sd100, 32'd2, 32'd1, 32'd100};
    load(); fc_done = 1'b1;
    scan_phase();
    chk("basic_class", result_class, 2);
    stream_phase(0, 1'b0);
    hold_ack();

    // All-negative scores, with an overrun edge and a stray ack during the stream.
    cur_sc = '{32'h8000_0000, -32'sd2, -32'sd5, -32'sd1000, -32'sd3,
               32'h8000_0001, -32'sd1, -32'sd2, -32'sd7, -32'sd2};
    load(); fc_done = 1'b1;
    scan_phase();
    chk("neg_class", result_class, 6);
    chk("neg_score", result_score, 32'hFFFF_FFFF);
    stream_phase(1, 1'b1);
    hold_ack();

    // Ack and new edge in the same HOLD cycle.
    rand_scores(); load(); fc_done = 1'b1;
    scan_phase();
    stream_phase(1, 1'b0);
    step();
    rand_scores(); load(); fc_done = 1'b1; result_ack = 1'b1;
    scan_phase();
    stream_phase(0, 1'b0);
    hold_ack();

    for (int r = 0; r < 3; r++) begin
      rand_scores(); load(); fc_done = 1'b1;
      scan_phase();
      stream_phase(1, 1'b0);
      hold_ack();
    end

    // Reset in the middle of a scan, then a clean run.
    rand_scores(); load(); fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    repeat (4) step();
    chk("midscan_busy", busy, 1);
    reset = 1'b1;
    step();
    chk_zero("midscan_reset");
    reset = 1'b0;
    step();
    rand_scores(); load(); fc_done = 1'b1;
    scan_phase();
    stream_phase(1, 1'b0);
    hold_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
